// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: registered PC driving instruction memory, plus a small
// circular fetch queue that buffers {pc, inst} pairs for decode.
module if_fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2,
    localparam int         INST_ADDR_LENGTH = 16,
    localparam int         INST_BUS_LENGTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [INST_ADDR_LENGTH-1:0] PC_o,
    input  logic [INST_BUS_LENGTH-1:0]  inst_i,
    input  logic                        redirect_i,
    input  logic [INST_ADDR_LENGTH-1:0] redirect_pc_i,
    output logic [INST_BUS_LENGTH-1:0]  inst_o,
    output logic [INST_ADDR_LENGTH-1:0] inst_pc_o,
    output logic                        inst_valid_o,
    input  logic                        inst_ready_i
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

    typedef struct packed {
        logic [INST_ADDR_LENGTH-1:0] pc;
        logic [INST_BUS_LENGTH-1:0]  inst;
    } entry_t;

    entry_t           mem [QDEPTH];
    logic [PTR_W-1:0] head, tail, head_nxt, tail_nxt;
    logic [CNT_W-1:0] count, count_nxt, remaining;
    occ_t             occ;
    logic             pop, push;
    entry_t           head_data_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        occ = PARTIAL;
        if (count == '0)
            occ = EMPTY;
        else if (count == FULL_CNT)
            occ = FULL;
    end

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign pop  = inst_valid_o & inst_ready_i;
    assign push = !redirect_i && ((occ != FULL) || pop);

    assign head_nxt  = pop  ? ptr_inc(head) : head;
    assign tail_nxt  = push ? ptr_inc(tail) : tail;
    assign remaining = pop  ? count - 1'b1  : count;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Head outputs are registered, so the next head is chosen here: an older entry
    // if one survives the pop, otherwise the pair being pushed straight through.
    always_comb begin
        head_data_nxt = '0;
        if (remaining != '0)
            head_data_nxt = mem[head_nxt];
        else if (push)
            head_data_nxt = '{pc: PC_o, inst: inst_i};
    end

    // NOTE: queue storage has no reset; validity is tracked by count and pointers alone.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[tail] <= '{pc: PC_o, inst: inst_i};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC_o         <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
        end else if (redirect_i) begin
            PC_o         <= redirect_pc_i;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
        end else begin
            if (push)
                PC_o <= PC_o + 1'b1;
            head         <= head_nxt;
            tail         <= tail_nxt;
            count        <= count_nxt;
            inst_valid_o <= (count_nxt != '0);
            inst_o       <= head_data_nxt.inst;
            inst_pc_o    <= head_data_nxt.pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (QDEPTH=2, RESET_PC=0); instruction memory
// returns 16'h8800 + PC so every delivered instruction is traceable to its PC.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] PC_o;
    logic [15:0] inst_i;
    logic        redirect_i = 1'b0;
    logic [15:0] redirect_pc_i = 16'h0000;
    logic [15:0] inst_o;
    logic [15:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;

    int total = 0;
    int bad   = 0;

    if_fetch_queue #(.RESET_PC(16'h0000), .QDEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_o          (PC_o),
        .inst_i        (inst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i)
    );

    always #5 clk = ~clk;

    assign inst_i = 16'h8800 + PC_o;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        valid;
        logic [15:0] pc;
        logic [15:0] ipc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic rdy, input logic rd, input logic [15:0] rpc,
                       input logic v, input logic [15:0] pc, input logic [15:0] ipc);
        vec_t x;
        x.rst = r; x.rdy = rdy; x.redir = rd; x.rpc = rpc;
        x.valid = v; x.pc = pc; x.ipc = ipc;
        vq.push_back(x);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] pc, input logic [15:0] ipc);
        logic [15:0] exp_inst;
        exp_inst = v ? 16'h8800 + ipc : 16'h0000;
        check({tag, ".valid"},   {15'd0, inst_valid_o}, {15'd0, v});
        check({tag, ".pc_o"},    PC_o, pc);
        check({tag, ".inst_pc"}, inst_pc_o, v ? ipc : 16'h0000);
        check({tag, ".inst"},    inst_o, exp_inst);
    endtask

    task automatic step(input logic r, input logic rdy, input logic rd, input logic [15:0] rpc);
        rst = r; inst_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // rst rdy redir rpc | valid pc_o inst_pc
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);  // reset
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 0, 0, 16'h0000, 1, 16'h0001, 16'h0000);  // stall: fill
        add(0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0000);
        add(0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0000);  // full, PC stops at 2
        add(0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'h0003, 16'h0001);  // drain in order, PC resumes
        add(0, 1, 0, 16'h0000, 1, 16'h0004, 16'h0002);
        add(0, 1, 0, 16'h0000, 1, 16'h0005, 16'h0003);
        add(0, 1, 0, 16'h0000, 1, 16'h0006, 16'h0004);
        add(1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);  // streaming from reset
        add(0, 1, 0, 16'h0000, 1, 16'h0001, 16'h0000);
        add(0, 1, 0, 16'h0000, 1, 16'h0002, 16'h0001);
        add(0, 1, 0, 16'h0000, 1, 16'h0003, 16'h0002);
        add(0, 1, 0, 16'h0000, 1, 16'h0004, 16'h0003);
        add(0, 1, 0, 16'h0000, 1, 16'h0005, 16'h0004);
        add(0, 1, 1, 16'h0018, 0, 16'h0018, 16'h0000);  // redirect to 24
        add(0, 1, 0, 16'h0000, 1, 16'h0019, 16'h0018);
        add(0, 1, 0, 16'h0000, 1, 16'h001A, 16'h0019);
        add(0, 0, 0, 16'h0000, 1, 16'h001B, 16'h0019);  // count reaches 2
        add(0, 1, 1, 16'h0100, 0, 16'h0100, 16'h0000);  // redirect + pop together
        add(0, 0, 0, 16'h0000, 1, 16'h0101, 16'h0100);
        add(0, 0, 1, 16'h0200, 0, 16'h0200, 16'h0000);  // back-to-back redirects
        add(0, 0, 1, 16'h0300, 0, 16'h0300, 16'h0000);
        add(0, 0, 0, 16'h0000, 1, 16'h0301, 16'h0300);
        add(1, 1, 1, 16'h0500, 0, 16'h0000, 16'h0000);  // reset beats redirect

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].rdy, vq[i].redir, vq[i].rpc);
            check_out($sformatf("vec%0d", i), vq[i].valid, vq[i].pc, vq[i].ipc);
        end

        // Wrap-around: redirect to 16'hFFFF while streaming.
        step(0, 1, 0, 16'h0000);
        step(0, 1, 0, 16'h0000);
        step(0, 1, 0, 16'h0000);
        check_out("wrap.pre", 1'b1, 16'h0003, 16'h0002);
        step(0, 1, 1, 16'hFFFF);
        check_out("wrap.redir", 1'b0, 16'hFFFF, 16'h0000);
        step(0, 1, 0, 16'h0000);
        check_out("wrap.ffff", 1'b1, 16'h0000, 16'hFFFF);
        step(0, 1, 0, 16'h0000);
        check_out("wrap.0000", 1'b1, 16'h0001, 16'h0000);

        // Reset mid-stream with two entries queued.
        step(0, 0, 0, 16'h0000);
        check_out("rstmid.full", 1'b1, 16'h0002, 16'h0000);
        step(1, 0, 0, 16'h0000);
        check_out("rstmid.rst", 1'b0, 16'h0000, 16'h0000);
        step(0, 0, 0, 16'h0000);
        check_out("rstmid.first", 1'b1, 16'h0001, 16'h0000);

        // Stream to PC 23, then redirect to 24: nothing older may surface.
        step(1, 1, 0, 16'h0000);
        for (int k = 0; k < 23; k++)
            step(0, 1, 0, 16'h0000);
        check_out("redir23.pre", 1'b1, 16'h0017, 16'h0016);
        step(0, 1, 1, 16'h0018);
        check_out("redir23.bubble", 1'b0, 16'h0018, 16'h0000);
        step(0, 1, 0, 16'h0000);
        check_out("redir23.target", 1'b1, 16'h0019, 16'h0018);
        step(0, 1, 0, 16'h0000);
        check_out("redir23.next", 1'b1, 16'h001A, 16'h0019);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 Parameter QDEPTH, default 2, meaning the number of fetch-queue entries; legal values are 2 to 4.
REQ-003 Widths come from defines.v: `INST_ADDR_LENGTH = 16 and `INST_BUS_LENGTH = 16.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port PC_o, output, `INST_ADDR_LENGTH bits: fetch address driven to instruction memory; it is the registered PC.
REQ-007 Port inst_i, input, `INST_BUS_LENGTH bits: instruction returned combinationally by instruction memory for PC_o in the same cycle.
REQ-008 Port redirect_i, input, 1 bit: a taken branch or jump from the execute stage; it flushes the queue and reloads the PC.
REQ-009 Port redirect_pc_i, input, `INST_ADDR_LENGTH bits: the target PC, sampled when redirect_i=1.
REQ-010 Port inst_o, output, `INST_BUS_LENGTH bits: the instruction at the queue head, presented to decode.
REQ-011 Port inst_pc_o, output, `INST_ADDR_LENGTH bits: the PC of the instruction at the queue head.
REQ-012 Port inst_valid_o, output, 1 bit: the queue head holds a valid instruction.
REQ-013 Port inst_ready_i, input, 1 bit: decode accepts the head this cycle.

Function
REQ-014 Pop occurs when inst_valid_o=1 and inst_ready_i=1; the head entry is removed at the clock edge.
REQ-015 Push occurs when redirect_i=0 and (count<QDEPTH, or count==QDEPTH with a pop in the same cycle).
- A push writes the pair {PC_o, inst_i} to the tail entry.
- A push sets PC_o <= PC_o+1.
REQ-016 With no push, PC_o holds its value (stall).
REQ-017 Occupancy count ranges from 0 to QDEPTH.
- Named states: EMPTY (count=0), PARTIAL (0<count<QDEPTH), FULL (count=QDEPTH).
- Push only: count+1.
- Pop only: count-1.
- Push and pop together: count unchanged.
REQ-018 The queue is a circular buffer.
- Head and tail pointers wrap modulo QDEPTH.
- Entries are delivered in strict push order.
REQ-019 inst_valid_o=1 exactly when count>0; the output is registered with no combinational path from inst_ready_i.
REQ-020 When count=0, inst_o=16'h0000 (the nop encoding) and inst_pc_o=16'h0000.
REQ-021 Redirect has priority over push and pop. When redirect_i=1, at the clock edge:
- PC_o <= redirect_pc_i;
- count <= 0;
- head and tail pointers <= 0;
- no push occurs, and an asserted pop is discarded.
REQ-022 Redirect timing:
- In the cycle after a redirect, inst_valid_o=0 and PC_o=redirect_pc_i.
- The target instruction is pushed in that cycle.
- The target is presented with inst_valid_o=1 in the cycle after that (redirect-to-valid latency is 2 clocks).
REQ-023 Fetch latency: an instruction pushed in cycle N is visible at the head in cycle N+1 when the queue was empty.
REQ-024 PC arithmetic is unsigned 16-bit; PC_o=16'hFFFF plus 1 wraps to 16'h0000 with no flag.
REQ-025 In steady state with inst_ready_i held at 1, throughput is one instruction per clock with no bubbles.
REQ-026 Back-to-back redirects in consecutive cycles are legal; the last redirect wins, and inst_valid_o stays 0 throughout.
REQ-027 Queue entry contents are not reset; only the pointers and count are reset.

Reset
REQ-028 When rst=1 at a clock edge:
- PC_o <= RESET_PC;
- count <= 0;
- pointers <= 0;
- inst_valid_o <= 0, inst_o <= 16'h0000, inst_pc_o <= 16'h0000.
REQ-029 rst has priority over redirect_i, push and pop.
REQ-030 Reset asserted mid-operation discards all queued instructions.
REQ-031 On the first edge after rst deasserts, the instruction at RESET_PC is pushed; inst_valid_o=1 on the following cycle.

Verification
REQ-032 Streaming: reset, then hold inst_ready_i=1 and return inst_i=16'h8800 to 16'h8804 for PC 0 to 4. Required: inst_pc_o=0,1,2,3,4 on consecutive cycles, all with inst_valid_o=1.
REQ-033 Stall and full: hold inst_ready_i=0 from reset with QDEPTH=2. Required:
- PC_o stops at 2 and count=2;
- after inst_ready_i=1, instructions for PC 0 and 1 emerge in order;
- PC_o then resumes at 2.
REQ-034 Redirect: while streaming at PC_o=23, assert redirect_i=1 with redirect_pc_i=24. Required:
- the next cycle has inst_valid_o=0 and PC_o=24;
- the cycle after has inst_pc_o=24 with inst_valid_o=1;
- no PC 23 or older entry reaches decode after the redirect.
REQ-035 Simultaneous events: with count=2, assert redirect_i=1 and inst_ready_i=1 together. Required: the queue is flushed, count=0, and PC_o=redirect_pc_i.
REQ-036 Wrap-around: redirect to 16'hFFFF while streaming. Required: inst_pc_o=16'hFFFF, then 16'h0000.
REQ-037 Reset mid-stream: assert rst for 1 cycle with count=2. Required: inst_valid_o=0 and PC_o=RESET_PC on the next cycle, then the instruction at RESET_PC is delivered.
